// File: rtl/risc_pkg.sv
// Shared types and constants for the 5-stage RISC hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package risc_pkg;

    // Hazard controller FSM states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    // EX operand source selects
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // Default number of flush cycles after a taken branch (legal 1..7)
    localparam int BR_PENALTY_DEF = 2;

endpackage

// File: rtl/hazard_ctrl_mod_fwd_unit.sv
// Operand forwarding select for one EX source operand.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
// Ports: rs (EX source), mem_rd/mem_wr and wb_rd/wb_wr (producer
// destinations and write flags), sel (FWD_RF / FWD_MEM / FWD_WB).
module fwd_unit_mod
    import risc_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wr,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_wr,
    output logic [1:0]        sel
);

    logic mem_hit;
    logic wb_hit;

    // r0 is hardwired zero, so a write to it never forwards
    assign mem_hit = mem_wr && (mem_rd != '0) && (mem_rd == rs);
    assign wb_hit  = wb_wr  && (wb_rd  != '0) && (wb_rd  == rs);

    // MEM holds the younger result, so it wins over WB
    assign sel = mem_hit ? FWD_MEM : (wb_hit ? FWD_WB : FWD_RF);

endmodule

// File: rtl/hazard_ctrl_mod.sv
// Hazard controller: forwarding selects, load-use bubble, branch flush, memory freeze, stall counter.
// Latency: all control outputs combinational from inputs and current state; counter updates next edge.
// Backpressure: a pending data-memory access freezes every pipeline register until dmem_ready_i.
// Ports: ID/EX/MEM/WB register fields and flags in; fwd_a_o/fwd_b_o selects, PC and
// pipeline-register enables/flushes, and stall_cnt_o (cycles with pc_en_o low) out.
module hazard_ctrl_mod
    import risc_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int BR_PENALTY = BR_PENALTY_DEF,
    parameter int CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs_a_i,
    input  logic [REG_AW-1:0] id_rs_b_i,
    input  logic              id_use_a_i,
    input  logic              id_use_b_i,
    input  logic [REG_AW-1:0] ex_rs_a_i,
    input  logic [REG_AW-1:0] ex_rs_b_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_reg_write_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_reg_write_i,
    input  logic              br_taken_i,
    input  logic              dmem_req_i,
    input  logic              dmem_ready_i,
    input  logic              cnt_clr_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              pc_en_o,
    output logic              if_id_en_o,
    output logic              if_id_flush_o,
    output logic              id_ex_en_o,
    output logic              id_ex_flush_o,
    output logic              ex_mem_en_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [2:0] FCNT_LOAD = 3'(BR_PENALTY - 1);

    hz_state_t  state, state_nxt;
    logic [2:0] fcnt, fcnt_nxt;
    logic       pend, pend_nxt;
    logic       lu;
    logic       mem_wait;

    fwd_unit_mod #(.REG_AW(REG_AW)) u_fwd_a (
        .rs     (ex_rs_a_i),
        .mem_rd (mem_rd_i),
        .mem_wr (mem_reg_write_i),
        .wb_rd  (wb_rd_i),
        .wb_wr  (wb_reg_write_i),
        .sel    (fwd_a_o)
    );

    fwd_unit_mod #(.REG_AW(REG_AW)) u_fwd_b (
        .rs     (ex_rs_b_i),
        .mem_rd (mem_rd_i),
        .mem_wr (mem_reg_write_i),
        .wb_rd  (wb_rd_i),
        .wb_wr  (wb_reg_write_i),
        .sel    (fwd_b_o)
    );

    assign lu = ex_mem_read_i && (ex_rd_i != '0) &&
                ((id_use_a_i && (id_rs_a_i == ex_rd_i)) ||
                 (id_use_b_i && (id_rs_b_i == ex_rd_i)));

    assign mem_wait = dmem_req_i && !dmem_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RUN;
            fcnt  <= 3'd0;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            pend  <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        fcnt_nxt      = fcnt;
        pend_nxt      = pend;
        pc_en_o       = 1'b1;
        if_id_en_o    = 1'b1;
        if_id_flush_o = 1'b0;
        id_ex_en_o    = 1'b1;
        id_ex_flush_o = 1'b0;
        ex_mem_en_o   = 1'b1;

        unique case (state)
            RUN: begin
                if (mem_wait) begin
                    pc_en_o     = 1'b0;
                    if_id_en_o  = 1'b0;
                    id_ex_en_o  = 1'b0;
                    ex_mem_en_o = 1'b0;
                    pend_nxt    = br_taken_i;
                    state_nxt   = MEM_WAIT;
                end else if (br_taken_i) begin
                    if_id_flush_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                    if (BR_PENALTY > 1) begin
                        fcnt_nxt  = FCNT_LOAD;
                        state_nxt = FLUSH;
                    end
                end else if (lu) begin
                    pc_en_o       = 1'b0;
                    if_id_en_o    = 1'b0;
                    id_ex_flush_o = 1'b1;
                end
            end
            FLUSH: begin
                if (mem_wait) begin
                    // fcnt is held so the remaining flush cycles resume after the wait
                    pc_en_o     = 1'b0;
                    if_id_en_o  = 1'b0;
                    id_ex_en_o  = 1'b0;
                    ex_mem_en_o = 1'b0;
                    pend_nxt    = pend || br_taken_i;
                    state_nxt   = MEM_WAIT;
                end else if (br_taken_i || pend) begin
                    // a new branch, or one captured during a memory wait, restarts the flush window
                    if_id_flush_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                    pend_nxt      = 1'b0;
                    if (BR_PENALTY > 1) begin
                        fcnt_nxt  = FCNT_LOAD;
                    end else begin
                        fcnt_nxt  = 3'd0;
                        state_nxt = RUN;
                    end
                end else begin
                    if_id_flush_o = 1'b1;
                    if (fcnt <= 3'd1) begin
                        fcnt_nxt  = 3'd0;
                        state_nxt = RUN;
                    end else begin
                        fcnt_nxt  = fcnt - 3'd1;
                    end
                end
            end
            MEM_WAIT: begin
                if (!dmem_ready_i) begin
                    pc_en_o     = 1'b0;
                    if_id_en_o  = 1'b0;
                    id_ex_en_o  = 1'b0;
                    ex_mem_en_o = 1'b0;
                end else begin
                    state_nxt = (pend || (fcnt != 3'd0)) ? FLUSH : RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        // While reset is held the pipeline runs freely with no flushes
        if (rst_i) begin
            pc_en_o       = 1'b1;
            if_id_en_o    = 1'b1;
            if_id_flush_o = 1'b0;
            id_ex_en_o    = 1'b1;
            id_ex_flush_o = 1'b0;
            ex_mem_en_o   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            stall_cnt_o <= '0;
        end else if (!pc_en_o && !(&stall_cnt_o)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_ctrl_mod.md
Name: hazard_ctrl_mod

Overview:
- Pipeline hazard controller for the 5-stage RISC (IF/ID/EX/MEM/WB).
- Per-cycle functions:
  - Produces operand forwarding selects for EX.
  - Inserts a bubble on a load-use hazard.
  - Flushes wrong-path instructions on a taken branch/jump for a programmable penalty.
  - Freezes the whole pipeline while data memory is not ready.
  - Keeps a saturating stall-cycle performance counter.
- Sits beside the ID/EX pipeline registers and drives every pipeline-register enable/flush.

Parameters:
REG_AW, 5, register address width (32 registers; r0 hardwired zero)
BR_PENALTY, 2, cycles of flush after a taken branch (legal 1..7)
CNT_W, 16, width of stall counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
id_rs_a_i  in  REG_AW  source A of instruction in ID
id_rs_b_i  in  REG_AW  source B of instruction in ID
id_use_a_i  in  1  ID instruction reads rs_a
id_use_b_i  in  1  ID instruction reads rs_b
ex_rs_a_i  in  REG_AW  source A of instruction in EX
ex_rs_b_i  in  REG_AW  source B of instruction in EX
ex_rd_i  in  REG_AW  destination of instruction in EX
ex_mem_read_i  in  1  EX instruction is a load
mem_rd_i  in  REG_AW  destination in MEM
mem_reg_write_i  in  1  MEM instruction writes a register
wb_rd_i  in  REG_AW  destination in WB
wb_reg_write_i  in  1  WB instruction writes a register
br_taken_i  in  1  EX resolved taken branch/jump
dmem_req_i  in  1  MEM stage access in progress
dmem_ready_i  in  1  data memory completes access this cycle
cnt_clr_i  in  1  synchronous clear of stall counter
fwd_a_o  out  2  EX operand A select: 0 regfile, 1 MEM result, 2 WB result
fwd_b_o  out  2  same for operand B
pc_en_o  out  1  PC register load enable
if_id_en_o  out  1  IF/ID register enable
if_id_flush_o  out  1  IF/ID becomes NOP
id_ex_en_o  out  1  ID/EX register enable
id_ex_flush_o  out  1  ID/EX becomes NOP
ex_mem_en_o  out  1  EX/MEM and MEM/WB enable
stall_cnt_o  out  CNT_W  cycles with pc_en_o=0 since reset/clear

Behaviour:
- Forwarding: combinational, independent of FSM.
  - fwd_a_o=1 if mem_reg_write_i && mem_rd_i!=0 && mem_rd_i==ex_rs_a_i.
  - Else fwd_a_o=2 if wb_reg_write_i && wb_rd_i!=0 && wb_rd_i==ex_rs_a_i.
  - Else 0. MEM beats WB. Same rules for B.
- Load-use detection: lu = ex_mem_read_i && ex_rd_i!=0 && ((id_use_a_i && id_rs_a_i==ex_rd_i) || (id_use_b_i && id_rs_b_i==ex_rd_i)).
- FSM states: RUN, FLUSH, MEM_WAIT. Reset state RUN; flush counter fcnt (3 bits) resets to 0.
- Priority each cycle: memory wait > branch > load-use.
- RUN:
  - dmem_req_i && !dmem_ready_i:
    - All enables 0, flushes 0.
    - Go to MEM_WAIT.
    - A concurrent br_taken_i is captured in a pending flag and applied on exit.
  - Else br_taken_i:
    - pc_en=1 (PC loads target), if_id_flush=1, id_ex_flush=1; other enables 1.
    - If BR_PENALTY>1: fcnt<=BR_PENALTY-1, go to FLUSH. Else stay RUN.
  - Else lu:
    - pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1.
    - Stay RUN; the bubble resolves the hazard next cycle.
  - Else all enables 1, flushes 0.
- FLUSH:
  - pc_en=1, if_id_flush=1, other enables 1; fcnt decrements each cycle.
  - Return to RUN when fcnt==1.
  - A memory wait in FLUSH takes priority: go to MEM_WAIT with fcnt held; resume FLUSH afterwards.
  - A new br_taken_i in FLUSH reloads fcnt and asserts id_ex_flush.
- MEM_WAIT:
  - All enables 0, flushes 0.
  - On dmem_ready_i, same cycle:
    - ex_mem_en=1, pc_en=1, if_id_en=1, id_ex_en=1.
    - Next state: FLUSH if the pending branch flag is set or fcnt>0, else RUN.
  - A pending branch is applied as a RUN-style branch cycle on exit.
- stall_cnt_o:
  - Increments on every cycle with pc_en_o=0; saturates at all-ones.
  - cnt_clr_i has priority over increment.
- Reset mid-operation: state RUN, fcnt 0, pending flag 0, counter 0 immediately (asynchronous).
  - Outputs during reset: all enables 1, flushes 0, fwd selects follow inputs.

Decomposition:
- Shared package (risc_pkg):
  - hz_state_t enum {RUN, FLUSH, MEM_WAIT}.
  - fwd_sel_t constants FWD_RF=0, FWD_MEM=1, FWD_WB=2.
  - Default BR_PENALTY constant.
- One sub-module, fwd_unit_mod: combinational forwarding compare, instantiated once per operand.

Test Plan:
- Forwarding: ex_rs_a=3, mem_rd=3 write=1, wb_rd=3 write=1 -> fwd_a_o=1. With mem write=0 -> 2. Repeat with rd=0 -> 0.
- Load-use: ex load rd=5, id rs_b=5 use_b=1 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1, stall_cnt +1. Next cycle normal.
- Branch, BR_PENALTY=2: br_taken pulse -> cycle0 if_id_flush=1 and id_ex_flush=1; cycle1 if_id_flush=1 only; cycle2 normal.
- Memory wait: dmem_req=1, ready low 3 cycles -> all enables 0 for 3 cycles, then released on the ready cycle. stall_cnt increases by 3.
- Simultaneous events: br_taken with dmem not ready -> freeze first, branch flush sequence applied after ready. Then assert rst_i mid-FLUSH -> outputs and counter reset immediately.
- Counter: force 0xFFFF then stall -> stays 0xFFFF. cnt_clr_i with a concurrent stall -> 0.
